// File: rtl/ibex_conv_window_gen.sv
// ibex_conv_window_gen
// Streaming 3x3 window generator. It takes a raster-order 8-bit pixel stream
// for one frame and keeps the two previous lines in line buffers. For each
// interior pixel it emits one packed 3x3 neighbourhood.
//   clk_i, rst_ni              clock, async active-low reset
//   start_i, cfg_width_i,
//   cfg_height_i               frame start request with its W/H (IDLE only)
//   pix_i, pix_valid_i,
//   pix_ready_o                pixel input handshake
//   win_o, win_valid_o,
//   win_ready_i, win_last_o    window output handshake (single-entry register)
//                              win_o byte k: C,N,S,W,E,NW,NE,SW,SE; [127:72]=0
//   busy_o                     not IDLE
//   frame_done_o               pulse after the final window is consumed
//   cfg_err_o                  pulse after a rejected start
module ibex_conv_window_gen #(
   parameter int MAX_WIDTH = 64,
   parameter int CW        = $clog2(MAX_WIDTH+1)
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           start_i,
   input  logic [CW-1:0]  cfg_width_i,
   input  logic [CW-1:0]  cfg_height_i,
   input  logic [7:0]     pix_i,
   input  logic           pix_valid_i,
   output logic           pix_ready_o,
   output logic [127:0]   win_o,
   output logic           win_valid_o,
   input  logic           win_ready_i,
   output logic           win_last_o,
   output logic           busy_o,
   output logic           frame_done_o,
   output logic           cfg_err_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam int            AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam logic [CW-1:0] MAX_W = CW'(MAX_WIDTH);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] row_q, row_d, col_q, col_d;
   logic [CW-1:0] width_q, width_d, height_q, height_d;
   logic [71:0]   win_q, win_d;
   logic          win_valid_q, win_valid_d;
   logic          win_last_q, win_last_d;
   logic          frame_done_q, frame_done_d;
   logic          cfg_err_q, cfg_err_d;
   // cols[i][j]: column i (0 = oldest, c-2) and row j (0 = r-2, 2 = current r)
   logic [2:0][2:0][7:0] cols_q, cols_d;

   logic [7:0] lb0 [MAX_WIDTH];   // row r-1
   logic [7:0] lb1 [MAX_WIDTH];   // row r-2

   logic [AW-1:0] lb_idx;
   logic [7:0]    a1, a2;
   logic          accept, last_col, last_pix, emit, cfg_ok;

   assign pix_ready_o  = (state_q == ST_RUN) && (!win_valid_q || win_ready_i);
   assign accept       = pix_valid_i && pix_ready_o;
   // Column never exceeds MAX_WIDTH-1, so the low bits are a full index.
   assign lb_idx       = col_q[AW-1:0];
   assign a1           = lb0[lb_idx];
   assign a2           = lb1[lb_idx];
   assign last_col     = (col_q == width_q - CW'(1));
   assign last_pix     = last_col && (row_q == height_q - CW'(1));
   // Rows/columns 0 and 1 only prime the buffers; this also hides stale
   // line-buffer data left over from the previous frame.
   assign emit         = accept && (row_q >= CW'(2)) && (col_q >= CW'(2));
   assign cfg_ok       = (cfg_width_i >= CW'(3)) && (cfg_width_i <= MAX_W) &&
                         (cfg_height_i >= CW'(3));

   assign win_o        = {56'd0, win_q};
   assign win_valid_o  = win_valid_q;
   assign win_last_o   = win_last_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign frame_done_o = frame_done_q;
   assign cfg_err_o    = cfg_err_q;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      width_d      = width_q;
      height_d     = height_q;
      cols_d       = cols_q;
      win_d        = win_q;
      win_valid_d  = win_valid_q;
      win_last_d   = win_last_q;
      frame_done_d = 1'b0;
      cfg_err_d    = 1'b0;

      if (accept) begin
         cols_d[0]    = cols_q[1];
         cols_d[1]    = cols_q[2];
         cols_d[2][0] = a2;
         cols_d[2][1] = a1;
         cols_d[2][2] = pix_i;
      end

      // Window is taken from the post-shift columns, centred at (r-1, c-1).
      if (emit) begin
         win_valid_d = 1'b1;
         win_last_d  = last_pix;
         win_d       = {cols_d[2][2], cols_d[0][2], cols_d[2][0], cols_d[0][0],
                        cols_d[2][1], cols_d[0][1], cols_d[1][2], cols_d[1][0],
                        cols_d[1][1]};
      end else if (win_ready_i) begin
         win_valid_d = 1'b0;
         win_last_d  = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               if (cfg_ok) begin
                  state_d  = ST_RUN;
                  width_d  = cfg_width_i;
                  height_d = cfg_height_i;
                  row_d    = '0;
                  col_d    = '0;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + CW'(1);
               end else begin
                  col_d = col_q + CW'(1);
               end
               if (last_pix) begin
                  state_d = ST_DRAIN;
                  row_d   = '0;
                  col_d   = '0;
               end
            end
         end
         ST_DRAIN: begin
            // The only pending window here is the last one of the frame.
            if (win_valid_q && win_ready_i) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         width_q      <= '0;
         height_q     <= '0;
         cols_q       <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         win_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         width_q      <= width_d;
         height_q     <= height_d;
         cols_q       <= cols_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         win_last_q   <= win_last_d;
         frame_done_q <= frame_done_d;
         cfg_err_q    <= cfg_err_d;
      end
   end

   // Line buffers hold no reset; contents are never observed before rewrite.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         lb1[lb_idx] <= a1;
         lb0[lb_idx] <= pix_i;
      end
   end

endmodule

// File: tb/tb_ibex_conv_window_gen.sv
module tb_ibex_conv_window_gen;
   localparam int MAXW = 64;
   localparam int CW   = $clog2(MAXW+1);

   logic           clk_i = 1'b0;
   logic           rst_ni = 1'b0;
   logic           start_i = 1'b0;
   logic [CW-1:0]  cfg_width_i = '0;
   logic [CW-1:0]  cfg_height_i = '0;
   logic [7:0]     pix_i = '0;
   logic           pix_valid_i = 1'b0;
   logic           pix_ready_o;
   logic [127:0]   win_o;
   logic           win_valid_o;
   logic           win_ready_i = 1'b0;
   logic           win_last_o;
   logic           busy_o;
   logic           frame_done_o;
   logic           cfg_err_o;

   ibex_conv_window_gen #(.MAX_WIDTH(MAXW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
      .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
      .win_o(win_o), .win_valid_o(win_valid_o), .win_ready_i(win_ready_i),
      .win_last_o(win_last_o), .busy_o(busy_o),
      .frame_done_o(frame_done_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int failures = 0;
   int frame_px [MAXW][MAXW];
   logic [127:0] got_first, got_last;

   typedef struct {
      int w;
      int h;
      int mode;     // pixel pattern if accepted
      bit exp_err;
   } cfg_vec_t;
   cfg_vec_t tv [6];

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // mode 0: 10r+c, 1: c, 2: constant k, 3: random
   task automatic fill(input int w, input int h, input int mode, input int k);
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            case (mode)
               0: frame_px[r][c] = 10*r + c;
               1: frame_px[r][c] = c;
               2: frame_px[r][c] = k;
               default: frame_px[r][c] = int'($urandom_range(255));
            endcase
   endtask

   // Reference window straight from the frame: neighbour offsets in output order.
   function automatic logic [127:0] win_of(input int r, input int c);
      int dr [9] = '{0, -1, 1, 0, 0, -1, -1, 1, 1};
      int dc [9] = '{0, 0, 0, -1, 1, -1, 1, -1, 1};
      logic [127:0] v = '0;
      for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'(frame_px[r+dr[k]][c+dc[k]]);
      return v;
   endfunction

   task automatic do_start(input int w, input int h);
      @(negedge clk_i);
      cfg_width_i  = CW'(w);
      cfg_height_i = CW'(h);
      start_i      = 1'b1;
      @(negedge clk_i);
      start_i      = 1'b0;
   endtask

   // Streams frame_px into the DUT (start already accepted) and scores windows.
   task automatic feed(input int w, input int h, input int vpct, input int rpct, input bit stall5);
      logic [127:0] exq [$];
      bit           lastq [$];
      logic [127:0] held, e;
      bit   held_last, prev_stall, last_hs, finished, stall_used, el;
      int   idx, nwin, cyc, stall_left, total;
      idx = 0; nwin = 0; cyc = 0; stall_left = 0; total = 0;
      prev_stall = 0; last_hs = 0; finished = 0; stall_used = 0;
      held = '0; held_last = 0;
      for (int r = 1; r <= h-2; r++)
         for (int c = 1; c <= w-2; c++) begin
            exq.push_back(win_of(r, c));
            lastq.push_back((r == h-2) && (c == w-2));
            total++;
         end
      while (!finished && cyc < 20000) begin
         @(negedge clk_i);
         cyc++;
         if (last_hs) begin
            chk("frame_done_after_last", {frame_done_o, busy_o}, 2'b10);
            finished = 1;
         end else begin
            if (frame_done_o) chk("early_frame_done", frame_done_o, 1'b0);
            if (prev_stall)
               chk("stall_hold", {win_last_o, win_valid_o, win_o}, {held_last, 1'b1, held});
            if (stall5 && !stall_used && win_valid_o) begin
               stall_left = 5;
               stall_used = 1;
            end
            pix_valid_i = (idx < w*h) && ($urandom_range(99) < vpct);
            pix_i = (idx < w*h) ? 8'(frame_px[idx/w][idx%w]) : 8'($urandom_range(255));
            if (stall_left > 0) begin
               win_ready_i = 1'b0;
               stall_left--;
            end else begin
               win_ready_i = ($urandom_range(99) < rpct);
            end
            #1;
            if (win_valid_o && !win_ready_i) chk("pix_ready_stall", pix_ready_o, 1'b0);
            else if (idx < w*h)              chk("pix_ready_run", pix_ready_o, 1'b1);
            if (win_valid_o && win_ready_i) begin
               if (exq.size() == 0) begin
                  chk("extra_window", win_o, '0);
               end else begin
                  e  = exq.pop_front();
                  el = lastq.pop_front();
                  chk("window", {win_last_o, win_o}, {el, e});
                  if (nwin == 0) got_first = win_o;
                  if (el) got_last = win_o;
                  last_hs = el;
               end
               nwin++;
            end
            prev_stall = win_valid_o && !win_ready_i;
            held       = win_o;
            held_last  = win_last_o;
            if (pix_valid_i && pix_ready_o) idx++;
         end
      end
      pix_valid_i = 1'b0;
      win_ready_i = 1'b0;
      if (!finished) begin
         failures++;
         $display("FAIL frame_timeout w=%0d h=%0d windows=%0d", w, h, nwin);
      end
      chk("window_count", nwin, total);
   endtask

   initial begin
      tv[0] = '{w: 2,  h: 5, mode: 0, exp_err: 1'b1};
      tv[1] = '{w: 65, h: 3, mode: 0, exp_err: 1'b1};
      tv[2] = '{w: 3,  h: 2, mode: 0, exp_err: 1'b1};
      tv[3] = '{w: 0,  h: 0, mode: 0, exp_err: 1'b1};
      tv[4] = '{w: 5,  h: 4, mode: 3, exp_err: 1'b0};
      tv[5] = '{w: 7,  h: 6, mode: 3, exp_err: 1'b0};

      #12;
      chk("reset_state", {pix_ready_o, win_valid_o, win_o, win_last_o, busy_o,
                          frame_done_o, cfg_err_o}, '0);
      rst_ni = 1'b1;

      // 4x4 basic frame
      fill(4, 4, 0, 0);
      do_start(4, 4);
      feed(4, 4, 100, 100, 1'b0);
      chk("first_4x4", got_first, {56'd0, 72'h16_14_02_00_0C_0A_15_01_0B});
      chk("last_4x4",  got_last,  {56'd0, 72'h21_1F_0D_0B_17_15_20_0C_16});

      // backpressure: 5-cycle stall after the first window
      do_start(4, 4);
      feed(4, 4, 100, 100, 1'b1);
      chk("bp_last_4x4", got_last, {56'd0, 72'h21_1F_0D_0B_17_15_20_0C_16});

      // config table, accepted entries streamed with random handshakes
      for (int i = 0; i < 6; i++) begin
         do_start(tv[i].w, tv[i].h);
         chk("cfg_resp", {cfg_err_o, busy_o, pix_ready_o},
             {tv[i].exp_err, !tv[i].exp_err, !tv[i].exp_err});
         if (tv[i].exp_err) begin
            @(negedge clk_i);
            chk("cfg_err_pulse", {cfg_err_o, busy_o}, 2'b00);
         end else begin
            fill(tv[i].w, tv[i].h, tv[i].mode, 0);
            feed(tv[i].w, tv[i].h, 70, 60, 1'b0);
         end
      end

      // full width, pixel = column
      fill(64, 3, 1, 0);
      do_start(64, 3);
      feed(64, 3, 100, 100, 1'b0);
      chk("fw_first", {got_first[39:32], got_first[31:24], got_first[7:0]}, {8'd2, 8'd0, 8'd1});
      chk("fw_last",  {got_last[39:32], got_last[31:24], got_last[7:0]}, {8'd63, 8'd61, 8'd62});

      // reset mid-frame after 7 pixels
      fill(4, 4, 0, 0);
      do_start(4, 4);
      for (int i = 0; i < 7; i++) begin
         pix_valid_i = 1'b1;
         pix_i = 8'(frame_px[i/4][i%4]);
         @(negedge clk_i);
      end
      pix_valid_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("reset_midframe", {pix_ready_o, win_valid_o, win_o, win_last_o, busy_o,
                             frame_done_o, cfg_err_o}, '0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      do_start(4, 4);
      feed(4, 4, 100, 100, 1'b0);
      chk("post_reset_first", got_first, {56'd0, 72'h16_14_02_00_0C_0A_15_01_0B});
      chk("post_reset_last",  got_last,  {56'd0, 72'h21_1F_0D_0B_17_15_20_0C_16});

      // back-to-back 3x3 frames: stale 100s must not leak into the 7s frame
      fill(3, 3, 2, 100);
      do_start(3, 3);
      feed(3, 3, 100, 100, 1'b0);
      fill(3, 3, 2, 7);
      do_start(3, 3);
      feed(3, 3, 100, 100, 1'b0);
      chk("b2b_stale", got_last, {56'd0, {9{8'd7}}});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ibex_conv_window_gen.md
# ibex_conv_window_gen

Streaming 3x3 window generator that feeds the vector convolution unit. It accepts a raster-order 8-bit pixel stream for one frame and buffers the two previous lines. For every interior pixel position it emits one packed 3x3 neighbourhood on a 128-bit bus, in the element order the vector logic unit's MAC lanes expect. A valid/ready handshake on both sides lets the pipeline stall without losing data.

## Interface

Parameters:

- MAX_WIDTH, 64: maximum line length in pixels; sets line-buffer depth (two buffers of MAX_WIDTH x 8 bits).
- CW, $clog2(MAX_WIDTH+1): width of the column and row configuration fields.

Ports:

- clk_i  in  1  clock; all state on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- start_i  in  1  one-cycle pulse that starts a frame; sampled only in IDLE.
- cfg_width_i  in  CW  frame width W; latched on start.
- cfg_height_i  in  CW  frame height H; latched on start.
- pix_i  in  8  pixel value, unsigned.
- pix_valid_i  in  1  pixel present.
- pix_ready_o  out  1  block accepts pixel.
- win_o  out  128  packed window, byte k = element k.
  - k=0 center, 1 N, 2 S, 3 W, 4 E, 5 NW, 6 NE, 7 SW, 8 SE.
  - bits [127:72] are zero.
- win_valid_o  out  1  window present.
- win_ready_i  in  1  consumer accepts window.
- win_last_o  out  1  high with the final window of the frame.
- busy_o  out  1  state is not IDLE.
- frame_done_o  out  1  one-cycle pulse when the final window is consumed.
- cfg_err_o  out  1  one-cycle pulse when a start request is rejected.

## Operation

- States:
  - IDLE: on start_i, go to RUN if 3<=W<=MAX_WIDTH and 3<=H. Otherwise pulse cfg_err_o and stay in IDLE.
  - RUN: accept pixels. Go to DRAIN on acceptance of the pixel at (H-1, W-1).
  - DRAIN: hold until the final window is consumed, then pulse frame_done_o and go to IDLE.
- start_i outside IDLE is ignored.
- Row and column counters track the next pixel (r,c). c wraps from W-1 to 0 and increments r.
- Pixel accept = pix_valid_i && pix_ready_o.
- pix_ready_o = (state==RUN) && (!win_valid_o || win_ready_i). The output is a single-entry register.
- On accept at column c:
  - read a1=lb0[c] (row r-1) and a2=lb1[c] (row r-2);
  - write lb1[c]<=a1 and lb0[c]<=pix_i;
  - shift the 3x3 column register left; the new right column is {a2, a1, pix_i}.
- Emission: an accept with r>=2 and c>=2 loads win_o with the window centred at (r-1, c-1) and sets win_valid_o. Exactly (W-2)*(H-2) windows are produced per frame; there is no edge padding.
- win_last_o is registered together with the window that completes (H-1, W-1).
- win_valid_o clears on win_ready_i unless a new window is loaded in the same cycle. Simultaneous consume and load is allowed.
- win_o, win_last_o and win_valid_o are stable while win_valid_o && !win_ready_i.
- Line-buffer contents are not cleared between frames; stale data is never emitted because of the r>=2 rule.

## Timing

- Reset values:
  - state=IDLE; counters 0.
  - pix_ready_o=0, win_valid_o=0, win_o=0, win_last_o=0, busy_o=0, frame_done_o=0, cfg_err_o=0.
  - Line buffers are not reset.
- Latency: a window is valid in the cycle after the accept that completes it.
- Throughput: one pixel and one window per cycle when win_ready_i is held high.
- cfg_err_o asserts the cycle after the rejected start_i. busy_o asserts the cycle after an accepted start_i.
- frame_done_o asserts the cycle after the final win handshake; the state is IDLE in that same cycle.
- Reset asserted mid-frame aborts immediately. No frame_done_o is produced, and the next frame needs a new start_i.

## Test plan

- **4x4 frame**, pixel value 10r+c, win_ready_i=1 → four windows.
  - First window: bytes 0..8 = 11,01,21,10,12,00,02,20,22.
  - Last window, centred at (2,2): 22,12,32,21,23,11,13,31,33, with win_last_o=1.
  - frame_done_o one cycle later.
- **Backpressure**: same frame, win_ready_i low for 5 cycles after the first window → pix_ready_o=0 and win_o held stable; no window is lost or duplicated; 4 windows in order.
- **Config errors**: start_i with W=2, H=5 → cfg_err_o pulse, busy_o=0, pix_ready_o=0. Repeat with W=MAX_WIDTH+1, H=3 → same response.
- **Full width**: W=64, H=3, pixel=c → 62 windows. Window n has center n+1 and W/E = n, n+2; only the last window has win_last_o=1.
- **Reset mid-frame**: rst_ni low after 7 pixels of a 4x4 frame → all outputs at reset values. A following 4x4 frame produces the four windows of the first scenario.
- **Back-to-back frames and stale data**: two consecutive 3x3 frames, values 100 then 7 → the second frame's window is all 7s.
